// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch and data stages; data wins ties; ready pulses MEM_LAT+1 cycles after acceptance.
// No backpressure beyond stalls: a requester is stalled while its request is pending, and one transaction runs at a time.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: begin
        // The memory-stage instruction is older, so it goes first.
        if (dm_req) begin
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          cnt_d   = 4'd0;
          state_d = BUSY_D;
        end else if (if_req) begin
          addr_d  = if_addr;
          we_d    = 1'b0;
          cnt_d   = 4'd0;
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if_rdata_d = mem_rdata;
          state_d    = RESP_I;
        end
      end
      BUSY_D: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          state_d = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the state register so an asynchronous reset drops them at once.
  assign mem_en    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_we    = (state_q == BUSY_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == RESP_I);
  assign dm_ready  = (state_q == RESP_D);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing tables on MEM_LAT=2 and MEM_LAT=1 instances,
// then random fetch/data traffic scored against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  logic clk = 1'b0;
  logic reset;

  // MEM_LAT=2 instance
  logic        if_req, if_ready, dm_req, dm_we, dm_ready, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  // MEM_LAT=1 instance
  logic        if_req1, if_ready1, dm_req1, dm_we1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1;
  logic [31:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  txn_t        fq[$];
  txn_t        dq[$];
  logic [31:0] ref_mem[256];
  logic [31:0] mem_arr[256];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  // Instruction space (>= 0x400) is a read-only pattern; data space is a small RAM.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  assign mem_rdata  = !mem_en ? 32'd0 :
                      (mem_addr < 32'h400) ? mem_arr[mem_addr[9:2]] : rom(mem_addr);
  assign mem_rdata1 = mem_en1 ? rom(mem_addr1) : 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
    end else if (mem_en && mem_we && mem_addr < 32'h400) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reinit_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks stalls, memory-side activity and completions against the queues.
  initial begin
    int          run;
    logic [31:0] exp_dm;
    txn_t        t;
    run = 0;
    exp_dm = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        exp_dm = 32'd0;
      end else begin
        chk1("stall_if", stall_if, if_req & ~if_ready);
        chk1("stall_mem", stall_mem, dm_req & ~dm_ready);
        if (mem_en) begin
          run++;
          if (mem_addr < 32'h400) begin
            if (dq.size() == 0) fail("mem_en_without_data_req");
            else begin
              chk32("mem_addr_d", mem_addr, dq[0].addr);
              chk1("mem_we_d", mem_we, dq[0].we);
              if (dq[0].we) chk32("mem_wdata", mem_wdata, dq[0].dat);
            end
          end else begin
            if (fq.size() == 0) fail("mem_en_without_fetch_req");
            else begin
              chk32("mem_addr_i", mem_addr, fq[0].addr);
              chk1("mem_we_i", mem_we, 1'b0);
            end
          end
        end else if (run != 0) begin
          chk1("ready_after_mem_en", if_ready | dm_ready, 1'b1);
          chk32("mem_en_len", 32'(run), 32'(LAT));
          run = 0;
        end
        if (if_ready) begin
          if (fq.size() == 0) fail("if_ready_unexpected");
          else begin
            t = fq.pop_front();
            chk32("if_rdata", if_rdata, t.dat);
          end
        end
        if (dm_ready) begin
          if (dq.size() == 0) fail("dm_ready_unexpected");
          else begin
            t = dq.pop_front();
            if (t.we) chk32("dm_rdata_hold_on_store", dm_rdata, exp_dm);
            else begin
              chk32("dm_rdata", dm_rdata, t.dat);
              exp_dm = t.dat;
            end
          end
        end
      end
    end
  end

  task automatic fetch_drv(input int n);
    logic [31:0] a;
    bit          got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step();
      a = 32'h3000 + 4 * $urandom_range(0, 255);
      if_addr = a;
      if_req = 1'b1;
      fq.push_back('{a, 1'b0, rom(a)});
      got = 0;
      for (int w = 0; w < 40 && !got; w++) begin
        @(negedge clk);
        if (if_ready) got = 1;
      end
      if (!got) fail("fetch_timeout");
      step();
      if_req = 1'b0;
    end
  endtask

  task automatic data_drv(input int n);
    logic [31:0] a, wd;
    logic        we;
    bit          got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) step();
      a = 4 * $urandom_range(0, 127);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      dm_addr = a;
      dm_we = we;
      dm_wdata = wd;
      dm_req = 1'b1;
      if (we) begin
        dq.push_back('{a, 1'b1, wd});
        ref_mem[a[9:2]] = wd;
      end else begin
        dq.push_back('{a, 1'b0, ref_mem[a[9:2]]});
      end
      got = 0;
      for (int w = 0; w < 40 && !got; w++) begin
        @(negedge clk);
        if (dm_ready) got = 1;
      end
      if (!got) fail("data_timeout");
      step();
      dm_req = 1'b0;
    end
  endtask

  initial begin
    int          last;
    bit          got;
    logic [31:0] a;
    reset = 1'b1;
    {if_req, dm_req, dm_we, if_req1, dm_req1, dm_we1} = '0;
    {if_addr, dm_addr, dm_wdata, if_addr1, dm_addr1, dm_wdata1} = '0;
    reinit_ref();

    // Reset held with random requests: everything reads zero, stalls follow requests.
    for (int k = 0; k < 3; k++) begin
      step();
      if_req = 1'($urandom_range(0, 1));
      dm_req = 1'($urandom_range(0, 1));
      dm_we = 1'($urandom_range(0, 1));
      if_addr = $urandom;
      dm_addr = $urandom;
      dm_wdata = $urandom;
      @(negedge clk);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_if_ready", if_ready, 1'b0);
      chk1("rst_dm_ready", dm_ready, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'd0);
      chk32("rst_mem_wdata", mem_wdata, 32'd0);
      chk32("rst_if_rdata", if_rdata, 32'd0);
      chk32("rst_dm_rdata", dm_rdata, 32'd0);
      chk1("rst_stall_if", stall_if, if_req);
      chk1("rst_stall_mem", stall_mem, dm_req);
      chk1("rst_mem_en1", mem_en1, 1'b0);
    end
    step();
    {if_req, dm_req, dm_we} = '0;
    reset = 1'b0;

    // Single fetch.
    if_addr = 32'h3000;
    if_req = 1'b1;
    fq.push_back('{32'h3000, 1'b0, rom(32'h3000)});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("f_mem_en", mem_en, k == 1 || k == 2);
      if (mem_en) chk32("f_mem_addr", mem_addr, 32'h3000);
      chk1("f_if_ready", if_ready, k == 3);
      if (k == 3) chk32("f_if_rdata", if_rdata, 32'h8C01_0004);
      chk1("f_stall_if", stall_if, k <= 2);
      step();
      if (k == 3) if_req = 1'b0;
    end

    // Store then load to 0x10.
    dm_addr = 32'h10;
    dm_wdata = 32'hDEAD_BEEF;
    dm_we = 1'b1;
    dm_req = 1'b1;
    dq.push_back('{32'h10, 1'b1, 32'hDEAD_BEEF});
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("st_mem_we", mem_we, k == 1 || k == 2);
      chk1("st_dm_ready", dm_ready, k == 3);
      if (k == 3) chk32("st_dm_rdata_unchanged", dm_rdata, 32'd0);
      step();
      if (k == 3) dm_req = 1'b0;
    end
    dm_we = 1'b0;
    dm_req = 1'b1;
    dq.push_back('{32'h10, 1'b0, 32'hDEAD_BEEF});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("ld_mem_we", mem_we, 1'b0);
      chk1("ld_dm_ready", dm_ready, k == 3);
      if (k == 3) chk32("ld_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      step();
      if (k == 3) dm_req = 1'b0;
    end

    // Simultaneous fetch and load: data first, fetch right after.
    if_addr = 32'h3004;
    if_req = 1'b1;
    dm_addr = 32'h20;
    dm_we = 1'b0;
    dm_req = 1'b1;
    fq.push_back('{32'h3004, 1'b0, rom(32'h3004)});
    dq.push_back('{32'h20, 1'b0, ref_mem[8]});
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk1("c_mem_en", mem_en, k == 1 || k == 2 || k == 5 || k == 6);
      chk1("c_dm_ready", dm_ready, k == 3);
      chk1("c_if_ready", if_ready, k == 7);
      chk1("c_stall_if", stall_if, k <= 6);
      step();
      if (k == 3) dm_req = 1'b0;
      if (k == 7) if_req = 1'b0;
    end

    // Reset between edges in the first BUSY cycle of a store.
    dm_addr = 32'h3F8;
    dm_wdata = 32'h1234_5678;
    dm_we = 1'b1;
    dm_req = 1'b1;
    step();
    chk1("rs_mem_en_before", mem_en, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk1("rs_mem_en_async", mem_en, 1'b0);
    chk1("rs_mem_we_async", mem_we, 1'b0);
    chk32("rs_if_rdata_async", if_rdata, 32'd0);
    chk32("rs_dm_rdata_async", dm_rdata, 32'd0);
    chk32("rs_mem_addr_async", mem_addr, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;
    reinit_ref();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("rs_no_dm_ready", dm_ready, 1'b0);
      step();
    end
    if_addr = 32'h3010;
    if_req = 1'b1;
    fq.push_back('{32'h3010, 1'b0, rom(32'h3010)});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("rs_f_mem_en", mem_en, k == 1 || k == 2);
      chk1("rs_f_if_ready", if_ready, k == 3);
      if (k == 3) chk32("rs_f_if_rdata", if_rdata, rom(32'h3010));
      step();
      if (k == 3) if_req = 1'b0;
    end

    // MEM_LAT=1: squashed fetch still completes, then a late load is accepted.
    if_addr1 = 32'h3008;
    if_req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("sq_mem_en", mem_en1, k == 1 || k == 4);
      chk1("sq_if_ready", if_ready1, k == 2);
      if (k == 2) chk32("sq_if_rdata", if_rdata1, rom(32'h3008));
      chk1("sq_stall_if", stall_if1, k == 0);
      chk1("sq_stall_mem", stall_mem1, k >= 2 && k <= 4);
      chk1("sq_dm_ready", dm_ready1, k == 5);
      if (k == 4) chk32("sq_mem_addr", mem_addr1, 32'h40);
      if (k == 5) chk32("sq_dm_rdata", dm_rdata1, rom(32'h40));
      step();
      if (k == 0) if_req1 = 1'b0;
      if (k == 1) begin
        dm_addr1 = 32'h40;
        dm_we1 = 1'b0;
        dm_req1 = 1'b1;
      end
      if (k == 5) dm_req1 = 1'b0;
    end

    // MEM_LAT=1: back-to-back fetches, one every three cycles.
    a = 32'h3100;
    if_addr1 = a;
    if_req1 = 1'b1;
    last = 0;
    for (int n = 0; n < 4; n++) begin
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (if_ready1) got = 1;
      end
      if (!got) fail("b2b_timeout");
      chk32("b2b_if_rdata", if_rdata1, rom(a));
      if (n > 0) chk32("b2b_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      step();
      a = a + 32'd4;
      if_addr1 = a;
    end
    if_req1 = 1'b0;

    // Random concurrent traffic on the MEM_LAT=2 instance.
    fork
      fetch_drv(40);
      data_drv(40);
    join
    repeat (6) step();
    chk32("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk32("data_queue_drained", 32'(dq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
